// File: rtl/mem_responder.sv
// Memory-side responder for the cpu memory bus.
// Word-organised RAM behind a small FSM: captures one request at a time, waits
// WAIT_STATES cycles, commits the access on the edge entering the ack cycle and
// pulses mem_ack (with mem_err on an error ack).
//
// Ports:
//   clk            - clock, rising edge
//   reset          - synchronous active-high reset
//   mem_read       - read request level, held until ack
//   mem_write      - write request level, held until ack
//   mem_addr       - byte address; word index = mem_addr[ADDR_BITS+1:2]
//   mem_write_data - write data
//   mem_ack        - one-cycle completion pulse
//   mem_read_data  - read data, held until the next ack
//   mem_err        - one-cycle error pulse coincident with mem_ack
//   busy           - high while a captured request waits for its ack
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic        mem_ack,
  output logic [31:0] mem_read_data,
  output logic        mem_err,
  output logic        busy
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            ram [Depth];

  logic                   req_valid;
  logic                   req_err;
  logic                   capture;
  logic                   commit;
  logic                   ram_we;
  logic [ADDR_BITS-1:0]   cur_idx;
  logic [31:0]            cur_wdata;
  logic                   cur_write;
  logic                   cur_err;

  // Byte-lane bits are ignored: accesses are always word aligned.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign req_valid = mem_read | mem_write;
  assign req_err   = (mem_read & mem_write) | ((mem_addr >> (ADDR_BITS + 2)) != 32'd0);
  assign capture   = (state_q == StIdle) & req_valid;

  // With zero wait states the capture edge is also the commit edge, so the
  // live request is used directly; otherwise the latched copy is used.
  always_comb begin
    if (capture) begin
      cur_idx   = mem_addr[ADDR_BITS+1:2];
      cur_wdata = mem_write_data;
      cur_write = mem_write & ~req_err;
      cur_err   = req_err;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_write = write_q;
      cur_err   = err_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = StAck;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign commit = (state_d == StAck);
  assign ram_we = commit & cur_write & ~reset;

  always_comb begin
    idx_d   = cur_idx;
    wdata_d = cur_wdata;
    write_d = cur_write;
    err_d   = cur_err;
    rdata_d = rdata_q;
    if (commit) begin
      if (cur_err) begin
        rdata_d = 32'd0;
      end else if (!cur_write) begin
        rdata_d = ram[cur_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[cur_idx] <= cur_wdata;
    end
  end

  // Outputs.
  always_comb begin
    mem_ack       = (state_q == StAck);
    mem_err       = (state_q == StAck) & err_q;
    busy          = (state_q == StWait);
    mem_read_data = rdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AB  = 10;
  localparam int WS1 = 3;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       ack;
  logic [1:0]       err;
  logic [1:0]       bsy;
  logic [1:0][31:0] rdata;

  int vectors = 0;
  int errors  = 0;

  // Reference model: word store and the read data the bus should show.
  logic [31:0] model [2][1024];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(0)) dut_ws0 (
    .clk            (clk),
    .reset          (rst[0]),
    .mem_read       (rd[0]),
    .mem_write      (wr[0]),
    .mem_addr       (addr[0]),
    .mem_write_data (wdata[0]),
    .mem_ack        (ack[0]),
    .mem_read_data  (rdata[0]),
    .mem_err        (err[0]),
    .busy           (bsy[0])
  );

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS1)) dut_ws3 (
    .clk            (clk),
    .reset          (rst[1]),
    .mem_read       (rd[1]),
    .mem_write      (wr[1]),
    .mem_addr       (addr[1]),
    .mem_write_data (wdata[1]),
    .mem_ack        (ack[1]),
    .mem_read_data  (rdata[1]),
    .mem_err        (err[1]),
    .busy           (bsy[1])
  );

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  // One bus transaction; returns at the negedge of the ack cycle.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, output time t_ack);
    int ws;
    int lat;
    bit got;
    bit e;
    int idx;
    ws  = (d == 0) ? 0 : WS1;
    @(posedge clk);
    #1;
    rd[d]    = r;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    e   = (r && w) || ((a >> (AB + 2)) != 0);
    idx = int'((a >> 2) % 1024);
    if (e) exp_rd[d] = 32'd0;
    else if (w) model[d][idx] = wd;
    else exp_rd[d] = model[d][idx];
    lat = 0;
    got = 1'b0;
    while (!got && lat <= ws + 4) begin
      @(negedge clk);
      if (ack[d]) got = 1'b1;
      else begin
        chk("busy_pre_ack", 32'(bsy[d]), 32'(lat >= 1 && lat <= ws));
        lat++;
      end
    end
    t_ack = $time;
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(lat), 32'(ws + 1));
      chk("err", 32'(err[d]), 32'(e));
      chk("rdata", rdata[d], exp_rd[d]);
      chk("busy_at_ack", 32'(bsy[d]), 32'd0);
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk);
    #1;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    @(negedge clk);
    chk("ack_single", 32'(ack[d]), 32'd0);
    chk("rdata_hold", rdata[d], exp_rd[d]);
  endtask

  initial begin
    time t0, t1;
    logic [31:0] a;
    int k;
    rst = 2'b11; rd = '0; wr = '0; addr = '0; wdata = '0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(ack[d]), 32'd0);
      chk("rst_err", 32'(err[d]), 32'd0);
      chk("rst_busy", 32'(bsy[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 2'b00;

    // Preload words 0..15 on both responders.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        txn(d, 1'b0, 1'b1, 32'(i * 4), $urandom, t0);
      end
      idle(d);
    end

    // Write then read back with zero wait states.
    txn(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, t0);
    idle(0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, t0);
    idle(0);

    // Three wait states: busy during the wait, single-cycle ack.
    txn(1, 1'b1, 1'b0, 32'h10, 32'h0, t0);
    idle(1);

    // Back-to-back reads, address advanced on each ack.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) txn(d, 1'b0, 1'b1, 32'(i * 4), 32'(i + 1), t0);
      idle(d);
      txn(d, 1'b1, 1'b0, 32'h0, 32'h0, t0);
      for (int i = 1; i < 4; i++) begin
        txn(d, 1'b1, 1'b0, 32'(i * 4), 32'h0, t1);
        chk("b2b_spacing", 32'(t1 - t0), 32'((2 + ((d == 0) ? 0 : WS1)) * 10));
        t0 = t1;
      end
      idle(d);
    end

    // Out-of-range read and simultaneous read+write.
    txn(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, t0);
    idle(0);
    txn(0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF, t0);
    idle(0);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, t0);
    idle(0);

    // Reset while a write sits in WAIT: write discarded, no ack.
    txn(1, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, t0);
    idle(1);
    @(posedge clk);
    #1;
    wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h12345678;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    wr[1]  = 1'b0;
    @(negedge clk);
    chk("busy_in_wait", 32'(bsy[1]), 32'd1);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    exp_rd[1] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_ack_after_rst", 32'(ack[1]), 32'd0);
      chk("busy_after_rst", 32'(bsy[1]), 32'd0);
      chk("rdata_after_rst", rdata[1], 32'd0);
    end
    txn(1, 1'b1, 1'b0, 32'h20, 32'h0, t0);
    idle(1);

    // Reset during the ack cycle: the committed write survives.
    @(posedge clk);
    #1;
    wr[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'h5A5A0001;
    model[0][9] = 32'h5A5A0001;
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    wr[0]  = 1'b0;
    @(negedge clk);
    chk("ack_before_rst", 32'(ack[0]), 32'd1);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    exp_rd[0] = 32'd0;
    @(negedge clk);
    chk("ack_cleared_rst", 32'(ack[0]), 32'd0);
    txn(0, 1'b1, 1'b0, 32'h24, 32'h0, t0);
    idle(0);

    // Unaligned read after aligned write.
    txn(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, t0);
    idle(0);
    txn(0, 1'b1, 1'b0, 32'h23, 32'h0, t0);
    idle(0);

    // Randomized traffic against the model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(7) == 0) begin
          a = (32'h1 << (12 + $urandom_range(19))) | 32'($urandom_range(63));
        end else begin
          a = 32'($urandom_range(63));
        end
        k = int'($urandom_range(9));
        if (k == 0) txn(d, 1'b1, 1'b1, a, $urandom, t0);
        else if (k < 5) txn(d, 1'b1, 1'b0, a, 32'h0, t0);
        else txn(d, 1'b0, 1'b1, a, $urandom, t0);
        if ($urandom_range(1) == 0) idle(d);
      end
      idle(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
